adsr_envelope: RTL
==================

Name: adsr_envelope

Overview:
- Per-voice amplitude envelope stage. It sits directly downstream of the sine oscillator and consumes its 16-bit signed sample every clk.
- Scales each sample by an attack/decay/sustain/release envelope that is driven by a note gate from the key-scan logic.
- Feeds the output mixer/DAC driver.
- Envelope state advances on a slow internal tick derived from the 1 MHz system clock.

Parameters:
- TICK_DIV, 1000: clk cycles per envelope update tick (1 kHz tick at 1 MHz clk).
- LVL_W, 16: envelope level width, unsigned; full scale = 2^LVL_W-1.

Ports:
- clk  in  1  system clock, 1 MHz, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- gate  in  1  note held; level-sensitive, synchronous to clk.
- sin  in  16  signed two's-complement oscillator sample.
- attack_rate  in  16  level increment per tick in ATTACK; 0 = jump to full scale.
- decay_rate  in  16  level decrement per tick in DECAY; 0 = jump to sustain_lvl.
- sustain_lvl  in  16  unsigned hold level in SUSTAIN.
- release_rate  in  16  level decrement per tick in RELEASE; 0 = jump to 0.
- sample_out  out  16  signed enveloped sample.
- env_level  out  16  current envelope level, unsigned.
- active  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any time, including mid-note): state=IDLE, level=0, tick counter=0, sample_out=0, env_level=0, active=0. Operation resumes on the first clk edge after rst deasserts.
- Tick: counter runs 0..TICK_DIV-1 and wraps. The tick pulse is one clk wide when counter==TICK_DIV-1. The counter free-runs and is not reset by gate.
- State transitions (FSM states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE) take effect on any clk, not only on ticks. Level arithmetic happens only on tick cycles.
- IDLE: gate=1 -> ATTACK. Level stays 0.
- ATTACK, on tick: level += attack_rate, computed in LVL_W+1 bits and saturated to 0xFFFF. Reaching 0xFFFF -> DECAY on the same update.
- DECAY, on tick: if level - decay_rate <= sustain_lvl, then level = sustain_lvl and go to SUSTAIN; otherwise subtract.
- SUSTAIN: level follows sustain_lvl every clk, so live changes are tracked.
- RELEASE, on tick: level -= release_rate, floored at 0. Reaching 0 -> IDLE.
- gate=0 in ATTACK/DECAY/SUSTAIN -> RELEASE, starting from the current level (no jump).
- gate=1 in RELEASE -> ATTACK, starting from the current level (retrigger without click).
- Gate edge and tick in the same cycle: apply the transition first. The new state's arithmetic starts on the next tick.
- Rate 0 means an instant jump, applied on the next tick.
- Output datapath: product = sin (signed 16) * {1'b0, level} (signed 17) = 33-bit signed; sample_out = product[31:16] (arithmetic >>16).
  - Latency: registered, exactly 1 clk from sin/level to sample_out.
  - Full-scale level yields sample_out = sin - (sin>>>16 rounding).
  - Specifically, sin=0x7FFF, level=0xFFFF -> 0x7FFE.
- env_level is the registered level, with the same timing as the level register.
- active is a registered decode of state.

Decomposition:
- Shared package synth_pkg holds:
  - State enum values (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4).
  - LVL_MAX constant.
  - The default TICK_DIV for the 1 MHz clock.
- One natural sub-module: env_scale. It is the registered signed 16x17 multiply and >>16 slice, reusable by the mixer for volume.
- The tick divider stays inline.

Test Plan:
- Reset mid-ATTACK with level=0x4000 -> same-cycle async clear: sample_out=0, env_level=0, active=0. State is IDLE after release of rst.
- TICK_DIV=4, attack_rate=0x4000, gate=1 -> level 0x4000, 0x8000, 0xC000, then 0xFFFF (saturated) on ticks 1-4. State is DECAY after tick 4.
- decay_rate=0x1000, sustain_lvl=0xF800 from 0xFFFF -> tick yields 0xF800 (floor), state SUSTAIN. Changing sustain_lvl to 0x8000 -> env_level=0x8000 within 2 clk.
- gate drop at level 0x3000 in SUSTAIN, release_rate=0x1000 -> RELEASE: 0x2000, 0x1000, 0x0000 on three ticks. IDLE and active=0 one clk after 0 is reached.
- Retrigger: gate=1 during RELEASE at level 0x2000 -> ATTACK continues from 0x2000 with no drop to 0.
- Datapath: level=0x8000, sin=0x7FFF -> sample_out=0x3FFF one clk later. sin=0x8000 -> 0xC000. level=0 -> 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path: envelope state codes, level full scale
// and the default tick divider for the 1 MHz system clock.
package synth_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int unsigned LVL_W_DEF    = 16;
  localparam logic [15:0] LVL_MAX      = 16'hFFFF;
  localparam int unsigned TICK_DIV_DEF = 1000;

endpackage

// File: rtl/env_scale.sv
// Registered signed sample x unsigned gain multiply; output is the product shifted
// right by the gain width (gain of all-ones is just under unity).
module env_scale #(
  parameter int unsigned W  = 16,
  parameter int unsigned GW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] sample,
  input  logic [GW-1:0]       gain,
  output logic signed [W-1:0] scaled
);

  logic signed [GW:0]     gain_s;
  logic signed [W+GW:0]   product;

  // Zero-extend the gain so it stays positive as a signed operand.
  assign gain_s  = $signed({1'b0, gain});
  assign product = sample * gain_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) scaled <= '0;
    else     scaled <= product[W+GW-1:GW];
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: level FSM advancing on a divided tick, with the
// oscillator sample scaled by the current level through env_scale.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned LVL_W    = LVL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gate,
  input  logic signed [15:0] sin,
  input  logic [LVL_W-1:0]   attack_rate,
  input  logic [LVL_W-1:0]   decay_rate,
  input  logic [LVL_W-1:0]   sustain_lvl,
  input  logic [LVL_W-1:0]   release_rate,
  output logic signed [15:0] sample_out,
  output logic [LVL_W-1:0]   env_level,
  output logic               active
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LVL_W-1:0] FULL = '1;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       state, state_next;
  logic [LVL_W-1:0] level, level_next;
  logic [LVL_W:0]   attack_sum;
  logic [LVL_W:0]   decay_floor;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign attack_sum  = {1'b0, level} + {1'b0, attack_rate};
  // level - decay_rate <= sustain_lvl, rearranged to avoid unsigned underflow.
  assign decay_floor = {1'b0, decay_rate} + {1'b0, sustain_lvl};

  // Gate-driven transitions take priority; arithmetic only runs when the state holds.
  always_comb begin
    state_next = state;
    level_next = level;
    case (state)
      ST_IDLE: begin
        if (gate) state_next = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_next = ST_RELEASE;
        end else if (tick) begin
          if (attack_rate == '0 || attack_sum >= {1'b0, FULL}) begin
            level_next = FULL;
            state_next = ST_DECAY;
          end else begin
            level_next = attack_sum[LVL_W-1:0];
          end
        end
      end
      ST_DECAY: begin
        if (!gate) begin
          state_next = ST_RELEASE;
        end else if (tick) begin
          if (decay_rate == '0 || {1'b0, level} <= decay_floor) begin
            level_next = sustain_lvl;
            state_next = ST_SUSTAIN;
          end else begin
            level_next = level - decay_rate;
          end
        end
      end
      ST_SUSTAIN: begin
        if (!gate) state_next = ST_RELEASE;
        else       level_next = sustain_lvl;
      end
      ST_RELEASE: begin
        if (gate) begin
          state_next = ST_ATTACK;
        end else if (tick) begin
          if (release_rate == '0 || level <= release_rate) begin
            level_next = '0;
            state_next = ST_IDLE;
          end else begin
            level_next = level - release_rate;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        level_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      level  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      level  <= level_next;
      active <= (state != ST_IDLE);
    end
  end

  assign env_level = level;

  env_scale #(
    .W  (16),
    .GW (LVL_W)
  ) u_scale (
    .clk    (clk),
    .rst    (rst),
    .sample (sin),
    .gain   (level),
    .scaled (sample_out)
  );

endmodule
